// File: rtl/e203_exu_oitf_trk.sv
// Outstanding instruction track FIFO for long-pipe instructions: allocates itags at
// dispatch, presents the oldest entry to write-back and flags RAW/WAW hazards.
module e203_exu_oitf_trk #(
  parameter int DEPTH       = 2,
  parameter int ITAG_WIDTH  = 1,
  parameter int RFIDX_WIDTH = 5,
  parameter int PC_SIZE     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   dis_ena,
  output logic                   dis_ready,
  output logic [ITAG_WIDTH-1:0]  dis_ptr,
  input  logic                   disp_i_rdwen,
  input  logic                   disp_i_rdfpu,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
  input  logic [PC_SIZE-1:0]     disp_i_pc,
  input  logic                   disp_i_rs1en,
  input  logic                   disp_i_rs2en,
  input  logic                   disp_i_rs3en,
  input  logic                   disp_i_rs1fpu,
  input  logic                   disp_i_rs2fpu,
  input  logic                   disp_i_rs3fpu,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs3idx,
  output logic                   oitfrd_match_disprs1,
  output logic                   oitfrd_match_disprs2,
  output logic                   oitfrd_match_disprs3,
  output logic                   oitfrd_match_disprd,

  input  logic                   ret_ena,
  output logic                   oitf_empty,
  output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
  output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
  output logic                   oitf_ret_rdwen,
  output logic                   oitf_ret_rdfpu,
  output logic [PC_SIZE-1:0]     oitf_ret_pc
);

  localparam logic [ITAG_WIDTH-1:0] LAST_PTR = ITAG_WIDTH'(DEPTH - 1);

  logic [ITAG_WIDTH-1:0]  alc_ptr_q, alc_ptr_d;
  logic [ITAG_WIDTH-1:0]  ret_ptr_q, ret_ptr_d;
  logic                   alc_flg_q, alc_flg_d;
  logic                   ret_flg_q, ret_flg_d;

  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [DEPTH-1:0]       rdwen_q;
  logic [DEPTH-1:0]       rdfpu_q;
  logic [RFIDX_WIDTH-1:0] rdidx_q [DEPTH];
  logic [PC_SIZE-1:0]     pc_q    [DEPTH];

  logic ptr_eq;
  logic empty;
  logic full;
  logic alc_fire;
  logic ret_fire;

  // Wrap flags disambiguate empty from full when the pointers coincide.
  assign ptr_eq    = (alc_ptr_q == ret_ptr_q);
  assign empty     = ptr_eq & (alc_flg_q == ret_flg_q);
  assign full      = ptr_eq & (alc_flg_q != ret_flg_q);

  assign dis_ready = ~full;
  assign alc_fire  = dis_ena & ~full;
  assign ret_fire  = ret_ena & ~empty;

  always_comb begin
    alc_ptr_d = alc_ptr_q;
    alc_flg_d = alc_flg_q;
    if (alc_fire) begin
      if (alc_ptr_q == LAST_PTR) begin
        alc_ptr_d = '0;
        alc_flg_d = ~alc_flg_q;
      end else begin
        alc_ptr_d = alc_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    ret_ptr_d = ret_ptr_q;
    ret_flg_d = ret_flg_q;
    if (ret_fire) begin
      if (ret_ptr_q == LAST_PTR) begin
        ret_ptr_d = '0;
        ret_flg_d = ~ret_flg_q;
      end else begin
        ret_ptr_d = ret_ptr_q + 1'b1;
      end
    end
  end

  // Allocate and retire never target the same slot: that needs empty or full,
  // and each of those blocks one of the two operations.
  always_comb begin
    vld_d = vld_q;
    if (ret_fire) vld_d[ret_ptr_q] = 1'b0;
    if (alc_fire) vld_d[alc_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alc_ptr_q <= '0;
      alc_flg_q <= 1'b0;
      ret_ptr_q <= '0;
      ret_flg_q <= 1'b0;
      vld_q     <= '0;
    end else begin
      alc_ptr_q <= alc_ptr_d;
      alc_flg_q <= alc_flg_d;
      ret_ptr_q <= ret_ptr_d;
      ret_flg_q <= ret_flg_d;
      vld_q     <= vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdwen_q <= '0;
      rdfpu_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdidx_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alc_fire && (alc_ptr_q == ITAG_WIDTH'(i))) begin
          rdwen_q[i] <= disp_i_rdwen;
          rdfpu_q[i] <= disp_i_rdfpu;
          rdidx_q[i] <= disp_i_rdidx;
          pc_q[i]    <= disp_i_pc;
        end
      end
    end
  end

  // Entries retiring this cycle still count: their result is not yet written back.
  always_comb begin
    oitfrd_match_disprs1 = 1'b0;
    oitfrd_match_disprs2 = 1'b0;
    oitfrd_match_disprs3 = 1'b0;
    oitfrd_match_disprd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && rdwen_q[i]) begin
        if (disp_i_rs1en && (disp_i_rs1idx == rdidx_q[i]) && (disp_i_rs1fpu == rdfpu_q[i]))
          oitfrd_match_disprs1 = 1'b1;
        if (disp_i_rs2en && (disp_i_rs2idx == rdidx_q[i]) && (disp_i_rs2fpu == rdfpu_q[i]))
          oitfrd_match_disprs2 = 1'b1;
        if (disp_i_rs3en && (disp_i_rs3idx == rdidx_q[i]) && (disp_i_rs3fpu == rdfpu_q[i]))
          oitfrd_match_disprs3 = 1'b1;
        if (disp_i_rdwen && (disp_i_rdidx == rdidx_q[i]) && (disp_i_rdfpu == rdfpu_q[i]))
          oitfrd_match_disprd = 1'b1;
      end
    end
  end

  assign dis_ptr        = alc_ptr_q;
  assign oitf_empty     = empty;
  assign oitf_ret_ptr   = ret_ptr_q;
  assign oitf_ret_rdidx = rdidx_q[ret_ptr_q];
  assign oitf_ret_rdwen = rdwen_q[ret_ptr_q];
  assign oitf_ret_rdfpu = rdfpu_q[ret_ptr_q];
  assign oitf_ret_pc    = pc_q[ret_ptr_q];

endmodule

// File: tb/tb_e203_exu_oitf_trk.sv
// Scoreboard bench for e203_exu_oitf_trk: a queue-based reference model predicts each
// cycle's outputs; a negedge monitor pops and compares them independently.
module tb_e203_exu_oitf_trk;
  localparam int DEPTH = 2;
  localparam int ITW   = 1;
  localparam int RFW   = 5;
  localparam int PCW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dis_ena = 1'b0, dis_ready;
  logic [ITW-1:0] dis_ptr, oitf_ret_ptr;
  logic disp_i_rdwen = 1'b0, disp_i_rdfpu = 1'b0;
  logic [RFW-1:0] disp_i_rdidx = '0;
  logic [PCW-1:0] disp_i_pc = '0;
  logic disp_i_rs1en = 1'b0, disp_i_rs2en = 1'b0, disp_i_rs3en = 1'b0;
  logic disp_i_rs1fpu = 1'b0, disp_i_rs2fpu = 1'b0, disp_i_rs3fpu = 1'b0;
  logic [RFW-1:0] disp_i_rs1idx = '0, disp_i_rs2idx = '0, disp_i_rs3idx = '0;
  logic m_rs1, m_rs2, m_rs3, m_rd;
  logic ret_ena = 1'b0, oitf_empty;
  logic [RFW-1:0] oitf_ret_rdidx;
  logic oitf_ret_rdwen, oitf_ret_rdfpu;
  logic [PCW-1:0] oitf_ret_pc;

  e203_exu_oitf_trk #(.DEPTH(DEPTH), .ITAG_WIDTH(ITW), .RFIDX_WIDTH(RFW), .PC_SIZE(PCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
    .disp_i_rdwen(disp_i_rdwen), .disp_i_rdfpu(disp_i_rdfpu),
    .disp_i_rdidx(disp_i_rdidx), .disp_i_pc(disp_i_pc),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rs3en(disp_i_rs3en),
    .disp_i_rs1fpu(disp_i_rs1fpu), .disp_i_rs2fpu(disp_i_rs2fpu), .disp_i_rs3fpu(disp_i_rs3fpu),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rs3idx(disp_i_rs3idx),
    .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
    .oitfrd_match_disprs3(m_rs3), .oitfrd_match_disprd(m_rd),
    .ret_ena(ret_ena), .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr),
    .oitf_ret_rdidx(oitf_ret_rdidx), .oitf_ret_rdwen(oitf_ret_rdwen),
    .oitf_ret_rdfpu(oitf_ret_rdfpu), .oitf_ret_pc(oitf_ret_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit dis, ret, rdwen, rdfpu;
    bit [RFW-1:0] rdidx;
    bit [PCW-1:0] pc;
    bit [2:0] rsen, rsfpu;
    bit [RFW-1:0] rs1, rs2, rs3;
  } stim_t;

  typedef struct {
    bit rdwen, rdfpu;
    bit [RFW-1:0] rdidx;
    bit [PCW-1:0] pc;
  } ent_t;

  typedef struct {
    bit ready, empty;
    bit [ITW-1:0] disptr, retptr;
    bit [3:0] match;
    bit ret_vld;
    ent_t ret;
  } exp_t;

  ent_t mdl_q[$];
  exp_t cyc_q[$];
  ent_t ret_q[$];
  int alc_cnt = 0;
  int ret_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Hazards: any outstanding entry with a destination equal (index and file) to a used operand.
  function automatic bit [3:0] exp_match(stim_t s);
    bit [3:0] m;
    m = '0;
    foreach (mdl_q[k]) begin
      if (mdl_q[k].rdwen) begin
        if (s.rsen[0] && s.rs1 == mdl_q[k].rdidx && s.rsfpu[0] == mdl_q[k].rdfpu) m[0] = 1'b1;
        if (s.rsen[1] && s.rs2 == mdl_q[k].rdidx && s.rsfpu[1] == mdl_q[k].rdfpu) m[1] = 1'b1;
        if (s.rsen[2] && s.rs3 == mdl_q[k].rdidx && s.rsfpu[2] == mdl_q[k].rdfpu) m[2] = 1'b1;
        if (s.rdwen && s.rdidx == mdl_q[k].rdidx && s.rdfpu == mdl_q[k].rdfpu) m[3] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic step(stim_t s);
    exp_t e;
    ent_t n;
    bit do_ret, do_alc;
    @(posedge clk);
    #1;
    dis_ena = s.dis; ret_ena = s.ret;
    disp_i_rdwen = s.rdwen; disp_i_rdfpu = s.rdfpu; disp_i_rdidx = s.rdidx; disp_i_pc = s.pc;
    disp_i_rs1en = s.rsen[0]; disp_i_rs2en = s.rsen[1]; disp_i_rs3en = s.rsen[2];
    disp_i_rs1fpu = s.rsfpu[0]; disp_i_rs2fpu = s.rsfpu[1]; disp_i_rs3fpu = s.rsfpu[2];
    disp_i_rs1idx = s.rs1; disp_i_rs2idx = s.rs2; disp_i_rs3idx = s.rs3;

    e = '{default: '0};
    e.ready   = (mdl_q.size() < DEPTH);
    e.empty   = (mdl_q.size() == 0);
    e.disptr  = ITW'(alc_cnt % DEPTH);
    e.retptr  = ITW'(ret_cnt % DEPTH);
    e.match   = exp_match(s);
    e.ret_vld = (mdl_q.size() > 0);
    if (e.ret_vld) e.ret = mdl_q[0];
    cyc_q.push_back(e);

    do_ret = s.ret && (mdl_q.size() > 0);
    do_alc = s.dis && (mdl_q.size() < DEPTH);
    if (do_ret) begin
      ret_q.push_back(mdl_q[0]);
      void'(mdl_q.pop_front());
      ret_cnt++;
    end
    if (do_alc) begin
      n.rdwen = s.rdwen; n.rdfpu = s.rdfpu; n.rdidx = s.rdidx; n.pc = s.pc;
      mdl_q.push_back(n);
      alc_cnt++;
    end
  endtask

  task automatic async_reset();
    step(idle());
    @(posedge clk);
    #2;
    chk("pre_rst_empty", oitf_empty, (mdl_q.size() == 0));
    rst_n = 1'b0;
    #1;
    chk("rst_empty", oitf_empty, 1);
    chk("rst_ready", dis_ready, 1);
    chk("rst_dis_ptr", dis_ptr, 0);
    chk("rst_ret_ptr", oitf_ret_ptr, 0);
    chk("rst_match", {m_rs1, m_rs2, m_rs3, m_rd}, 0);
    mdl_q.delete();
    ret_q.delete();
    alc_cnt = 0;
    ret_cnt = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    ent_t r;
    if (rst_n) begin
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("dis_ready", dis_ready, e.ready);
        chk("oitf_empty", oitf_empty, e.empty);
        chk("dis_ptr", dis_ptr, e.disptr);
        chk("oitf_ret_ptr", oitf_ret_ptr, e.retptr);
        chk("match_rs1", m_rs1, e.match[0]);
        chk("match_rs2", m_rs2, e.match[1]);
        chk("match_rs3", m_rs3, e.match[2]);
        chk("match_rd", m_rd, e.match[3]);
        if (e.ret_vld) begin
          chk("ret_rdidx", oitf_ret_rdidx, e.ret.rdidx);
          chk("ret_rdwen", oitf_ret_rdwen, e.ret.rdwen);
          chk("ret_rdfpu", oitf_ret_rdfpu, e.ret.rdfpu);
          chk("ret_pc", oitf_ret_pc, e.ret.pc);
        end
      end
      if (ret_ena && !oitf_empty) begin
        if (ret_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL retire_unexpected: got retire expected none (t=%0t)", $time);
        end else begin
          r = ret_q.pop_front();
          chk("retired_pc", oitf_ret_pc, r.pc);
          chk("retired_rdidx", oitf_ret_rdidx, r.rdidx);
        end
      end
    end
  end

  initial begin
    stim_t s;
    #12;
    chk("init_empty", oitf_empty, 1);
    chk("init_ready", dis_ready, 1);
    chk("init_dis_ptr", dis_ptr, 0);
    chk("init_match", {m_rs1, m_rs2, m_rs3, m_rd}, 0);
    rst_n = 1'b1;

    step(idle());
    s = idle(); s.dis = 1; s.rdwen = 1; s.rdidx = 5; s.pc = 32'h8000_0010;
    step(s);
    step(idle());
    s = idle(); s.dis = 1; s.rdwen = 1; s.rdfpu = 1; s.rdidx = 7; s.pc = 32'h8000_0020;
    step(s);
    s = idle(); s.rsen = 3'b001; s.rsfpu = 3'b001; s.rs1 = 7;
    step(s);
    s.rsfpu = 3'b000;
    step(s);
    s = idle(); s.rsen = 3'b000; s.rsfpu = 3'b010; s.rs2 = 7;
    step(s);
    s = idle(); s.dis = 1; s.rdwen = 1; s.rdidx = 11; s.pc = 32'h8000_00f0;
    step(s);
    s = idle(); s.ret = 1;
    step(s);
    s = idle(); s.dis = 1; s.rdwen = 1; s.rdidx = 9; s.pc = 32'h8000_0030;
    step(s);
    s = idle(); s.ret = 1;
    step(s);
    s = idle(); s.dis = 1; s.ret = 1; s.rdwen = 1; s.rdidx = 12; s.pc = 32'h8000_0040;
    step(s);
    step(idle());
    s = idle(); s.dis = 1; s.rdwen = 1; s.rdidx = 3; s.pc = 32'h8000_0050;
    step(s);
    async_reset();
    step(idle());

    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.dis   = ($urandom_range(0, 9) < 6);
      s.ret   = ($urandom_range(0, 9) < 5);
      s.rdwen = ($urandom_range(0, 3) != 0);
      s.rdfpu = $urandom_range(0, 1);
      s.rdidx = RFW'($urandom_range(0, 3));
      s.pc    = $urandom;
      s.rsen  = 3'($urandom_range(0, 7));
      s.rsfpu = 3'($urandom_range(0, 7));
      s.rs1   = RFW'($urandom_range(0, 3));
      s.rs2   = RFW'($urandom_range(0, 3));
      s.rs3   = RFW'($urandom_range(0, 3));
      step(s);
    end
    step(idle());
    @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/e203_exu_oitf_trk.md
Name: e203_exu_oitf_trk

Overview:
Outstanding Instruction Track FIFO for long-pipe instructions (LSU, NICE). Dispatch allocates one entry per long-pipe instruction and receives an itag. The block supplies the long-pipe write-back arbiter with the oldest entry's itag, rd index, rd write-enable, FPU flag and PC, and frees that entry when the arbiter pulses ret_ena. It also reports RAW/WAW hazards between the dispatching instruction and all outstanding entries.

Parameters:
DEPTH, 2, number of entries; power of 2, >=2
ITAG_WIDTH, 1, log2(DEPTH); width of an itag
RFIDX_WIDTH, 5, register-file index width
PC_SIZE, 32, PC width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
dis_ena  in  1  allocate an entry this cycle (dispatch handshake done)
dis_ready  out  1  an entry is free
dis_ptr  out  ITAG_WIDTH  itag granted to the allocating instruction
disp_i_rdwen  in  1  allocating instruction writes rd
disp_i_rdfpu  in  1  rd is in the FP register file
disp_i_rdidx  in  RFIDX_WIDTH  rd index
disp_i_pc  in  PC_SIZE  PC of the allocating instruction
disp_i_rs1en/rs2en/rs3en  in  1 each  source operand used
disp_i_rs1fpu/rs2fpu/rs3fpu  in  1 each  source is an FP register
disp_i_rs1idx/rs2idx/rs3idx  in  RFIDX_WIDTH each  source indices
oitfrd_match_disprs1/rs2/rs3  out  1 each  RAW hazard on that source
oitfrd_match_disprd  out  1  WAW hazard on rd
ret_ena  in  1  retire the oldest entry
oitf_empty  out  1  no valid entries
oitf_ret_ptr  out  ITAG_WIDTH  itag of the oldest entry
oitf_ret_rdidx  out  RFIDX_WIDTH  oldest entry rd index
oitf_ret_rdwen  out  1  oldest entry rd write-enable
oitf_ret_rdfpu  out  1  oldest entry FP flag
oitf_ret_pc  out  PC_SIZE  oldest entry PC

Behaviour:
- State:
  - alc_ptr and ret_ptr, each ITAG_WIDTH bits plus a wrap flag.
  - Per-entry registers: vld, rdwen, rdfpu, rdidx, pc.
  - All state resets asynchronously to 0.
- Reset values: dis_ready=1, oitf_empty=1, dis_ptr=0, oitf_ret_ptr=0, every ret_* output 0, every match output 0.
- Empty/full:
  - empty = (alc_ptr==ret_ptr) and wrap flags equal.
  - full = (alc_ptr==ret_ptr) and wrap flags differ.
  - dis_ready = ~full. Ready does not depend on ret_ena in the same cycle, so there is no combinational path from ret_ena to dis_ready.
- Allocate:
  - On dis_ena & dis_ready, the entry at alc_ptr is written: vld=1 plus the disp_i_rd*/pc fields.
  - alc_ptr then increments. At DEPTH-1 it wraps to 0 and the wrap flag toggles.
  - dis_ptr = current alc_ptr, combinational, valid in the allocating cycle.
  - dis_ena while full is ignored: no state change.
- Retire:
  - On ret_ena & ~empty, entry[ret_ptr].vld clears and ret_ptr increments with the same wrap rule.
  - ret_ena while empty is ignored.
  - oitf_ret_* are combinational reads of entry[ret_ptr]. They hold their last contents when empty; consumers must qualify them with oitf_empty.
- Simultaneous allocate and retire: both take effect in the same cycle.
  - With one entry valid, the new entry is written and the old one freed; occupancy stays 1.
  - When empty, only the allocation takes effect.
  - When full, only the retire takes effect, because dis_ready=0.
- Hazard detect (combinational, no latency). For each valid entry i with rdwen=1:
  - rsN hit = rsNen & (rsNidx==rdidx_i) & (rsNfpu==rdfpu_i).
  - rd hit = disp_i_rdwen & (rdidx==rdidx_i) & (rdfpu==rdfpu_i).
  - Each oitfrd_match_* output is the OR over all entries.
  - Index 0 of the integer file is not special-cased; the dispatch stage masks x0.
  - An entry retiring in the current cycle still counts as matching.
- Latency: allocation is visible to oitf_empty and the match outputs the cycle after dis_ena. A retire is visible the cycle after ret_ena.
- Reset asserted mid-operation flushes all entries immediately, without waiting for a clock edge.

Test Plan:
- Reset with DEPTH=2 -> oitf_empty=1, dis_ready=1, dis_ptr=0, all match outputs 0.
- Allocate rd=x5 int, pc=0x80000010; next cycle -> oitf_empty=0, ret_ptr=0, ret_rdidx=5, ret_pc=0x80000010, dis_ptr=1.
- Allocate two entries -> dis_ready=0; a third dis_ena is ignored; ret_ena -> next cycle ret_ptr=1, dis_ready=1, and the next allocation gets dis_ptr=0 with the wrap flag toggled.
- Entry rd=x7 fp outstanding; dispatch rs1=x7 fp with rs1en=1 -> match_disprs1=1; the same with rs1fpu=0 -> 0; rs2en=0 with rs2=x7 -> match_disprs2=0.
- One entry valid; dis_ena and ret_ena in the same cycle -> occupancy stays 1, ret_ptr advances by 1, and the new entry's fields appear on ret_*.
- Two entries valid; rst_n pulled low between clock edges -> oitf_empty=1 and dis_ready=1 immediately, pointers 0.
